// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Runs one request/ack data-memory transaction per load or
// store. It builds the byte enables and the lane-replicated store data, and it sign- or
// zero-extends the load data. It stalls upstream stages while an access is in flight. It flags
// misaligned accesses, illegal accesses and bus timeouts.
// Ports:
//   stg_clk, reset_n                        clock, async active-low reset
//   address_in, rd_memory, wr_memory,
//   funct3_in, rs2_data_in                  EX/MEM latch request
//   dmem_addr/wdata/be/rd/wr (out),
//   dmem_ack/rdata (in)                     data-memory bus
//   load_data_out, mem_done, mem_stall      result / handshake to the pipeline
//   misalign_exc, illegal_exc, bus_err      one-cycle error pulses
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        stg_clk,
    input  logic        reset_n,
    input  logic [31:0] address_in,
    input  logic        rd_memory,
    input  logic        wr_memory,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] rs2_data_in,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_rd,
    output logic        dmem_wr,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        misalign_exc,
    output logic        illegal_exc,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    state_t state_q, state_d;

    logic [31:0]      dmem_addr_q, dmem_addr_d;
    logic [31:0]      dmem_wdata_q, dmem_wdata_d;
    logic [3:0]       dmem_be_q, dmem_be_d;
    logic             dmem_rd_q, dmem_rd_d;
    logic             dmem_wr_q, dmem_wr_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             mem_done_q, mem_done_d;
    logic             misalign_q, misalign_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;

    // Request decode
    logic op, illegal, misalign, timeout_hit;
    logic [31:0] byte_sh, half_sh, load_ext;

    assign op          = rd_memory | wr_memory;
    assign illegal     = (rd_memory & wr_memory) |
                         (rd_memory & (funct3_in == 3'b011 || funct3_in[2:1] == 2'b11)) |
                         (wr_memory & funct3_in[2]) |
                         (wr_memory & (funct3_in[1:0] == 2'b11));
    assign misalign    = ((funct3_in[1:0] == 2'b01) & address_in[0]) |
                         ((funct3_in[1:0] == 2'b10) & (address_in[1:0] != 2'b00));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Load lane extract, using the size/offset captured at accept time
    assign byte_sh = dmem_rdata >> {addr_lo_q, 3'b000};
    assign half_sh = dmem_rdata >> {addr_lo_q[1], 4'b0000};
    always_comb begin
        load_ext = dmem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  load_ext = {24'h0, byte_sh[7:0]};
            3'b101:  load_ext = {16'h0, half_sh[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op) state_d = (illegal || misalign) ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        dmem_rd_d    = dmem_rd_q;
        dmem_wr_d    = dmem_wr_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        load_data_d  = 32'h0;
        mem_done_d   = 1'b0;
        misalign_d   = 1'b0;
        illegal_d    = 1'b0;
        bus_err_d    = 1'b0;
        cnt_d        = '0;
        // Gated by reset so the stall drops together with the rest of the outputs
        mem_stall    = reset_n & (((state_q == ST_IDLE) & op) | (state_q == ST_REQ));
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (illegal) begin
                        illegal_d  = 1'b1;
                        mem_done_d = 1'b1;
                    end else if (misalign) begin
                        misalign_d = 1'b1;
                        mem_done_d = 1'b1;
                    end else begin
                        dmem_addr_d = {address_in[31:2], 2'b00};
                        dmem_rd_d   = rd_memory;
                        dmem_wr_d   = wr_memory;
                        f3_d        = funct3_in;
                        addr_lo_d   = address_in[1:0];
                        if (rd_memory) begin
                            dmem_be_d    = 4'b1111;
                            dmem_wdata_d = 32'h0;
                        end else begin
                            case (funct3_in[1:0])
                                2'b00: begin
                                    dmem_be_d    = 4'(4'b0001 << address_in[1:0]);
                                    dmem_wdata_d = {4{rs2_data_in[7:0]}};
                                end
                                2'b01: begin
                                    dmem_be_d    = 4'(4'b0011 << {address_in[1], 1'b0});
                                    dmem_wdata_d = {2{rs2_data_in[15:0]}};
                                end
                                default: begin
                                    dmem_be_d    = 4'b1111;
                                    dmem_wdata_d = rs2_data_in;
                                end
                            endcase
                        end
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack wins over a same-cycle timeout
                if (dmem_ack) begin
                    dmem_rd_d   = 1'b0;
                    dmem_wr_d   = 1'b0;
                    mem_done_d  = 1'b1;
                    load_data_d = dmem_rd_q ? load_ext : 32'h0;
                    cnt_d       = '0;
                end else if (timeout_hit) begin
                    dmem_rd_d  = 1'b0;
                    dmem_wr_d  = 1'b0;
                    mem_done_d = 1'b1;
                    bus_err_d  = 1'b1;
                    cnt_d      = '0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            dmem_be_q    <= 4'h0;
            dmem_rd_q    <= 1'b0;
            dmem_wr_q    <= 1'b0;
            load_data_q  <= 32'h0;
            mem_done_q   <= 1'b0;
            misalign_q   <= 1'b0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
            f3_q         <= 3'b000;
            addr_lo_q    <= 2'b00;
        end else begin
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            dmem_rd_q    <= dmem_rd_d;
            dmem_wr_q    <= dmem_wr_d;
            load_data_q  <= load_data_d;
            mem_done_q   <= mem_done_d;
            misalign_q   <= misalign_d;
            illegal_q    <= illegal_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_rd       = dmem_rd_q;
    assign dmem_wr       = dmem_wr_q;
    assign load_data_out = load_data_q;
    assign mem_done      = mem_done_q;
    assign misalign_exc  = misalign_q;
    assign illegal_exc   = illegal_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        stg_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address_in = '0;
    logic        rd_memory = 1'b0;
    logic        wr_memory = 1'b0;
    logic [2:0]  funct3_in = '0;
    logic [31:0] rs2_data_in = '0;
    logic [31:0] dmem_addr, dmem_wdata, load_data_out;
    logic [3:0]  dmem_be;
    logic        dmem_rd, dmem_wr, mem_done, mem_stall, misalign_exc, illegal_exc, bus_err;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .stg_clk(stg_clk), .reset_n(reset_n),
        .address_in(address_in), .rd_memory(rd_memory), .wr_memory(wr_memory),
        .funct3_in(funct3_in), .rs2_data_in(rs2_data_in),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .load_data_out(load_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .misalign_exc(misalign_exc), .illegal_exc(illegal_exc), .bus_err(bus_err)
    );

    always #5 stg_clk = ~stg_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: expected results derived from the ISA rules
    function automatic bit ref_illegal(input bit rd, input bit wr, input int f3);
        if (rd && wr) return 1;
        if (rd) return !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return !(f3 == 0 || f3 == 1 || f3 == 2);
    endfunction

    function automatic bit ref_misalign(input int f3, input logic [31:0] addr);
        int sz = f3 % 4;
        if (sz == 1) return (addr % 2) != 0;
        if (sz == 2) return (addr % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            4: return b;
            5: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input bit rd, input int f3, input logic [31:0] addr);
        if (rd) return 4'hF;
        if (f3 == 0) return 4'(1 << (addr % 4));
        if (f3 == 1) return 4'(3 << (2 * ((addr / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input bit rd, input int f3, input logic [31:0] d);
        if (rd) return 32'h0;
        if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // One full access; called right after a rising edge with the DUT in IDLE.
    // delay = REQ cycle index (0-based) in which ack is given; >= TIMEOUT means never.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int delay);
        bit exc_ill = ref_illegal(rd, wr, int'(f3));
        bit exc_mis = !exc_ill && ref_misalign(int'(f3), addr);
        bit exc     = exc_ill || exc_mis;
        bit tmo     = !exc && delay >= TIMEOUT;
        logic [31:0] exp_ld = (rd && !exc && !tmo) ? ref_load(int'(f3), addr, rdata) : 32'h0;
        rd_memory = rd; wr_memory = wr; funct3_in = f3;
        address_in = addr; rs2_data_in = data; dmem_rdata = rdata;
        @(negedge stg_clk);
        check_val("stall_idle_op", 32'(mem_stall), 32'd1);
        @(posedge stg_clk); #1;
        if (!exc) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                dmem_ack = (k == delay);
                @(negedge stg_clk);
                check_val("req_rd", 32'(dmem_rd), 32'(rd));
                check_val("req_wr", 32'(dmem_wr), 32'(wr));
                check_val("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                check_val("req_be", 32'(dmem_be), 32'(ref_be(rd, int'(f3), addr)));
                check_val("req_wdata", dmem_wdata, ref_wdata(rd, int'(f3), data));
                check_val("req_stall", 32'(mem_stall), 32'd1);
                check_val("req_done", 32'(mem_done), 32'd0);
                @(posedge stg_clk); #1;
                if (k == delay) break;
            end
            dmem_ack = 1'b0;
        end
        @(negedge stg_clk);
        check_val("done_pulse", 32'(mem_done), 32'd1);
        check_val("done_illegal", 32'(illegal_exc), 32'(exc_ill));
        check_val("done_misalign", 32'(misalign_exc), 32'(exc_mis));
        check_val("done_bus_err", 32'(bus_err), 32'(tmo));
        check_val("done_load", load_data_out, exp_ld);
        check_val("done_rdwr", 32'({dmem_rd, dmem_wr}), 32'd0);
        check_val("done_stall", 32'(mem_stall), 32'd0);
        @(posedge stg_clk); #1;
        rd_memory = 1'b0; wr_memory = 1'b0;
        @(negedge stg_clk);
        check_val("idle_done", 32'(mem_done), 32'd0);
        check_val("idle_pulses", 32'({misalign_exc, illegal_exc, bus_err, dmem_rd, dmem_wr}), 32'd0);
        @(posedge stg_clk); #1;
    endtask

    initial begin
        #12;
        check_val("rst_outputs", 32'({dmem_rd, dmem_wr, mem_done, mem_stall, misalign_exc, illegal_exc, bus_err}), 32'd0);
        check_val("rst_addr", dmem_addr, 32'h0);
        check_val("rst_be", 32'(dmem_be), 32'h0);
        check_val("rst_load", load_data_out, 32'h0);
        @(posedge stg_clk); #1;
        reset_n = 1'b1;
        @(posedge stg_clk); #1;

        // Directed vectors
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        run_op(1, 0, 3'b000, 32'h203, 32'h0, 32'h80123456, 0);
        run_op(1, 0, 3'b100, 32'h203, 32'h0, 32'h80123456, 1);
        run_op(1, 0, 3'b101, 32'h202, 32'h0, 32'h80123456, 0);
        run_op(0, 1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 1);
        run_op(0, 1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        run_op(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678, TIMEOUT + 4);
        run_op(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);

        // Reset in the middle of a REQ phase
        rd_memory = 1'b1; funct3_in = 3'b010; address_in = 32'h200;
        @(posedge stg_clk); #1;
        @(posedge stg_clk); #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst_ctl", 32'({dmem_rd, dmem_wr, mem_done, mem_stall, bus_err}), 32'd0);
        check_val("midrst_addr", dmem_addr, 32'h0);
        check_val("midrst_be", 32'(dmem_be), 32'h0);
        @(posedge stg_clk); #1;
        rd_memory = 1'b0;
        @(negedge stg_clk);
        check_val("midrst_nodone", 32'(mem_done), 32'd0);
        @(posedge stg_clk); #1;
        reset_n = 1'b1;
        @(posedge stg_clk); #1;
        run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h0BADC0DE, 1);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            int sel = $urandom_range(0, 9);
            bit rd = (sel < 5) || (sel == 9);
            bit wr = (sel >= 5);
            int dly = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 4);
            run_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, dly);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
